wordle_engine: RTL

Parametrised Wordle game core that generalises the fixed five-letter game state machine. It accepts serial letter entry with backspace and submit, and scores each guess against a loaded answer word with correct duplicate-letter handling. It produces per-letter green/yellow/gray feedback, a guess counter and win/lose flags. The block sits between the keypad/letter decoder and the display driver; the answer word comes from the word-select block.

---
 rtl/wordle_engine.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wordle_engine.sv
// Wordle game core: serial letter entry, two-pass duplicate-aware scoring, win/lose tracking.
// Optional hard-mode submit check is built when WORDLE_HARD_MODE_EN is defined.
//
// state     | meaning
// IDLE      | waiting for start
// ENTRY     | accepting letters, backspace, submit
// HCHECK    | hard-mode delay cycle before scoring (hard mode only)
// SCORE_G   | mark exact matches green, reserve those answer slots
// SCORE_Y   | one guess position per cycle: yellow or gray
// REPORT    | feedback_valid pulse, then back to ENTRY or on to DONE
// DONE      | game over, waiting for ack
module wordle_engine #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [8*WORD_LEN-1:0]         answer,
    input  logic [7:0]                    letter_in,
    input  logic                          letter_valid,
    output logic                          letter_ready,
    input  logic                          backspace,
    input  logic                          submit,
    input  logic                          ack,
    output logic [8*WORD_LEN-1:0]         guess_out,
    output logic [$clog2(WORD_LEN+1)-1:0] cursor,
    output logic [3:0]                    row,
    output logic [2*WORD_LEN-1:0]         feedback,
    output logic                          feedback_valid,
    output logic                          reject,
    output logic                          busy,
    output logic                          win,
    output logic                          lose
);

    localparam int CW = $clog2(WORD_LEN + 1);
    localparam int YW = $clog2(WORD_LEN);
    localparam logic [1:0] FB_GRAY   = 2'b01;
    localparam logic [1:0] FB_YELLOW = 2'b10;
    localparam logic [1:0] FB_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_HCHECK, S_SCORE_G, S_SCORE_Y, S_REPORT, S_DONE
    } state_t;

    state_t state, state_n;

    logic [7:0]          ans_q    [WORD_LEN];
    logic [7:0]          gbuf     [WORD_LEN];
    logic [1:0]          fb_work  [WORD_LEN];
    logic [1:0]          fb_next  [WORD_LEN];
    logic [1:0]          fb_pub   [WORD_LEN];
    logic [WORD_LEN-1:0] used;
    logic [YW-1:0]       y_cnt;

    logic                in_entry, row_full, is_alpha, last_guess, y_last;
    logic                do_bs, do_sub, do_let;
    logic [WORD_LEN-1:0] cur_pos, match_oh;
    logic [7:0]          cur_letter;
    logic                cur_green, match, all_green;

    always_comb begin
        guess_out = '0;
        feedback  = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            guess_out[8*(WORD_LEN-1-i) +: 8] = gbuf[i];
            feedback[2*(WORD_LEN-1-i) +: 2]  = fb_pub[i];
        end
    end

    assign in_entry     = (state == S_ENTRY);
    assign row_full     = (cursor == CW'(WORD_LEN));
    assign letter_ready = in_entry && !row_full;
    assign busy         = (state == S_SCORE_G) || (state == S_SCORE_Y) || (state == S_REPORT);
    assign is_alpha     = (letter_in >= 8'h41) && (letter_in <= 8'h5A);
    assign last_guess   = (row == 4'(MAX_GUESSES - 1));
    assign y_last       = (y_cnt == '0);

    assign do_bs  = in_entry && backspace;
    assign do_sub = in_entry && !backspace && submit;
    assign do_let = in_entry && !backspace && !submit && letter_valid && letter_ready;

    // y_cnt counts down, so the position being scored is WORD_LEN-1-y_cnt.
    always_comb begin
        cur_pos    = '0;
        cur_letter = '0;
        cur_green  = 1'b0;
        match      = 1'b0;
        match_oh   = '0;
        all_green  = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (y_cnt == YW'(WORD_LEN - 1 - i)) begin
                cur_pos[i] = 1'b1;
                cur_letter = gbuf[i];
                cur_green  = (fb_work[i] == FB_GREEN);
            end
        end
        for (int j = 0; j < WORD_LEN; j++) begin
            if (!match && !used[j] && ans_q[j] == cur_letter) begin
                match       = 1'b1;
                match_oh[j] = 1'b1;
            end
        end
        for (int i = 0; i < WORD_LEN; i++) begin
            fb_next[i] = fb_work[i];
            if (cur_pos[i] && !cur_green)
                fb_next[i] = match ? FB_YELLOW : FB_GRAY;
            if (fb_next[i] != FB_GREEN)
                all_green = 1'b0;
        end
    end

`ifdef WORDLE_HARD_MODE_EN
    logic [7:0] prev_guess [WORD_LEN];
    logic       hard_ok, seen;

    // fb_pub still holds the last scored row, so it doubles as the hint record.
    always_comb begin
        hard_ok = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (fb_pub[i] == FB_GREEN && gbuf[i] != prev_guess[i])
                hard_ok = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < WORD_LEN; k++)
                if (gbuf[k] == prev_guess[i])
                    seen = 1'b1;
            if (fb_pub[i] == FB_YELLOW && !seen)
                hard_ok = 1'b0;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = S_ENTRY;
        end else begin
            case (state)
                S_IDLE:    state_n = S_IDLE;
                S_ENTRY: begin
                    if (do_sub && row_full) begin
`ifdef WORDLE_HARD_MODE_EN
                        if (hard_ok)
                            state_n = S_HCHECK;
`else
                        state_n = S_SCORE_G;
`endif
                    end
                end
                S_HCHECK:  state_n = S_SCORE_G;
                S_SCORE_G: state_n = S_SCORE_Y;
                S_SCORE_Y: if (y_last) state_n = S_REPORT;
                S_REPORT:  state_n = (win || lose) ? S_DONE : S_ENTRY;
                S_DONE:    if (ack) state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            cursor         <= '0;
            row            <= '0;
            feedback_valid <= 1'b0;
            reject         <= 1'b0;
            win            <= 1'b0;
            lose           <= 1'b0;
            used           <= '0;
            y_cnt          <= '0;
            for (int i = 0; i < WORD_LEN; i++) begin
                ans_q[i]   <= '0;
                gbuf[i]    <= '0;
                fb_work[i] <= '0;
                fb_pub[i]  <= '0;
`ifdef WORDLE_HARD_MODE_EN
                prev_guess[i] <= '0;
`endif
            end
        end else begin
            feedback_valid <= 1'b0;
            reject         <= 1'b0;
            if (start) begin
                cursor <= '0;
                row    <= '0;
                win    <= 1'b0;
                lose   <= 1'b0;
                used   <= '0;
                for (int i = 0; i < WORD_LEN; i++) begin
                    ans_q[i]   <= answer[8*(WORD_LEN-1-i) +: 8];
                    gbuf[i]    <= '0;
                    fb_work[i] <= '0;
                    fb_pub[i]  <= '0;
                end
            end else begin
                case (state)
                    S_ENTRY: begin
                        if (do_bs) begin
                            if (cursor != '0) begin
                                for (int i = 0; i < WORD_LEN; i++)
                                    if (CW'(i + 1) == cursor)
                                        gbuf[i] <= '0;
                                cursor <= cursor - CW'(1);
                            end
                        end else if (do_sub) begin
                            if (!row_full)
                                reject <= 1'b1;
`ifdef WORDLE_HARD_MODE_EN
                            else if (!hard_ok)
                                reject <= 1'b1;
`endif
                        end else if (do_let) begin
                            if (is_alpha) begin
                                for (int i = 0; i < WORD_LEN; i++)
                                    if (CW'(i) == cursor)
                                        gbuf[i] <= letter_in;
                                cursor <= cursor + CW'(1);
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end
                    S_SCORE_G: begin
                        for (int i = 0; i < WORD_LEN; i++) begin
                            fb_work[i] <= (gbuf[i] == ans_q[i]) ? FB_GREEN : 2'b00;
                            used[i]    <= (gbuf[i] == ans_q[i]);
                        end
                        y_cnt <= YW'(WORD_LEN - 1);
                    end
                    S_SCORE_Y: begin
                        for (int i = 0; i < WORD_LEN; i++)
                            fb_work[i] <= fb_next[i];
                        if (!cur_green)
                            used <= used | match_oh;
                        y_cnt <= y_cnt - YW'(1);
                        // Publish on the final scoring edge so REPORT shows the result.
                        if (y_last) begin
                            for (int i = 0; i < WORD_LEN; i++) begin
                                fb_pub[i] <= fb_next[i];
`ifdef WORDLE_HARD_MODE_EN
                                prev_guess[i] <= gbuf[i];
`endif
                            end
                            feedback_valid <= 1'b1;
                            row            <= row + 4'd1;
                            if (all_green)
                                win <= 1'b1;
                            else if (last_guess)
                                lose <= 1'b1;
                        end
                    end
                    S_REPORT: begin
                        if (!win && !lose) begin
                            cursor <= '0;
                            for (int i = 0; i < WORD_LEN; i++)
                                gbuf[i] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
